// File: rtl/tt_um_jleugeri_ttt_event_router.sv
// Event router: buffers per-source start/end pulses and serializes them round-robin
// into signed good/bad token increments. Optional sticky overflow flag: TTT_ROUTER_OVERFLOW_EN.
module tt_um_jleugeri_ttt_event_router #(
  parameter int NUM_SOURCES     = 4,
  parameter int SRC_BITS        = $clog2(NUM_SOURCES),
  parameter int NEW_TOKENS_BITS = 4
) (
  input  logic                              clock_fast,
  input  logic                              reset,
  input  logic [NUM_SOURCES-1:0]            src_token_start,
  input  logic [NUM_SOURCES-1:0]            src_token_end,
  input  logic                              cfg_write,
  input  logic [SRC_BITS-1:0]               cfg_addr,
  input  logic signed [NEW_TOKENS_BITS-1:0] cfg_weight,
  input  logic                              cfg_is_bad,
  output logic signed [NEW_TOKENS_BITS-1:0] new_good_tokens,
  output logic signed [NEW_TOKENS_BITS-1:0] new_bad_tokens,
  output logic                              busy
`ifdef TTT_ROUTER_OVERFLOW_EN
  ,
  output logic                              overflow
`endif
);

  localparam logic signed [NEW_TOKENS_BITS-1:0] W_MIN = {1'b1, {(NEW_TOKENS_BITS-1){1'b0}}};
  localparam logic signed [NEW_TOKENS_BITS-1:0] W_MAX = {1'b0, {(NEW_TOKENS_BITS-1){1'b1}}};

  logic signed [NEW_TOKENS_BITS-1:0] weight_reg [NUM_SOURCES];
  logic [NUM_SOURCES-1:0]            is_bad_reg;
  logic [NUM_SOURCES-1:0]            pend_start_reg;
  logic [NUM_SOURCES-1:0]            pend_end_reg;
  logic [NUM_SOURCES-1:0]            clear_start;
  logic [NUM_SOURCES-1:0]            clear_end;
  logic [SRC_BITS-1:0]               rr_reg;
  logic [SRC_BITS-1:0]               rr_next;

  logic                              sel_valid;
  logic [SRC_BITS-1:0]               sel_src;
  logic                              sel_is_end;
  logic signed [NEW_TOKENS_BITS-1:0] sel_weight;
  logic signed [NEW_TOKENS_BITS-1:0] incr;
  logic signed [NEW_TOKENS_BITS-1:0] good_next;
  logic signed [NEW_TOKENS_BITS-1:0] bad_next;

  assign busy = |{pend_start_reg, pend_end_reg};

  // Scan registered pending bits from rr upward, first hit wins; start before end.
  always_comb begin
    int idx;
    int nxt;
    logic [SRC_BITS-1:0] cand;
    idx        = 0;
    nxt        = 0;
    cand       = '0;
    sel_valid  = 1'b0;
    sel_src    = '0;
    sel_is_end = 1'b0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      idx = int'(rr_reg) + k;
      if (idx >= NUM_SOURCES) idx = idx - NUM_SOURCES;
      cand = SRC_BITS'(idx);
      if (!sel_valid && (pend_start_reg[cand] || pend_end_reg[cand])) begin
        sel_valid  = 1'b1;
        sel_src    = cand;
        sel_is_end = !pend_start_reg[cand];
      end
    end
    nxt = int'(sel_src) + 1;
    if (nxt >= NUM_SOURCES) nxt = 0;
    rr_next = sel_valid ? SRC_BITS'(nxt) : rr_reg;
  end

  always_comb begin
    clear_start = '0;
    clear_end   = '0;
    if (sel_valid) begin
      if (sel_is_end) clear_end[sel_src]   = 1'b1;
      else            clear_start[sel_src] = 1'b1;
    end
  end

  // End events negate the weight; the most-negative weight saturates instead of wrapping.
  always_comb begin
    sel_weight = weight_reg[sel_src];
    incr       = sel_weight;
    if (sel_is_end) incr = (sel_weight == W_MIN) ? W_MAX : -sel_weight;
    good_next  = '0;
    bad_next   = '0;
    if (sel_valid) begin
      if (is_bad_reg[sel_src]) bad_next  = incr;
      else                     good_next = incr;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SOURCES; gi++) begin : g_src
      always_ff @(posedge clock_fast) begin
        if (reset) begin
          weight_reg[gi]     <= '0;
          is_bad_reg[gi]     <= 1'b0;
          pend_start_reg[gi] <= 1'b0;
          pend_end_reg[gi]   <= 1'b0;
        end else begin
          if (cfg_write && (cfg_addr == SRC_BITS'(gi))) begin
            weight_reg[gi] <= cfg_weight;
            is_bad_reg[gi] <= cfg_is_bad;
          end
          pend_start_reg[gi] <= (pend_start_reg[gi] & ~clear_start[gi]) | src_token_start[gi];
          pend_end_reg[gi]   <= (pend_end_reg[gi] & ~clear_end[gi]) | src_token_end[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clock_fast) begin
    if (reset) begin
      rr_reg          <= '0;
      new_good_tokens <= '0;
      new_bad_tokens  <= '0;
    end else begin
      rr_reg          <= rr_next;
      new_good_tokens <= good_next;
      new_bad_tokens  <= bad_next;
    end
  end

`ifdef TTT_ROUTER_OVERFLOW_EN
  logic dup_event;
  assign dup_event = |((src_token_start & pend_start_reg & ~clear_start) |
                       (src_token_end   & pend_end_reg   & ~clear_end));

  always_ff @(posedge clock_fast) begin
    if (reset) overflow <= 1'b0;
    else if (dup_event) overflow <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_event_router.sv
// Directed bench for the event router: routing, ordering, saturation, duplicates, reset.
module tb_tt_um_jleugeri_ttt_event_router;

  logic              clock_fast;
  logic              reset;
  logic [3:0]        src_token_start;
  logic [3:0]        src_token_end;
  logic              cfg_write;
  logic [1:0]        cfg_addr;
  logic signed [3:0] cfg_weight;
  logic              cfg_is_bad;
  logic signed [3:0] new_good_tokens;
  logic signed [3:0] new_bad_tokens;
  logic              busy;
`ifdef TTT_ROUTER_OVERFLOW_EN
  logic              overflow;
`endif

  int vec_count  = 0;
  int miscompares = 0;

  tt_um_jleugeri_ttt_event_router #(
    .NUM_SOURCES(4),
    .SRC_BITS(2),
    .NEW_TOKENS_BITS(4)
  ) dut (
    .clock_fast(clock_fast),
    .reset(reset),
    .src_token_start(src_token_start),
    .src_token_end(src_token_end),
    .cfg_write(cfg_write),
    .cfg_addr(cfg_addr),
    .cfg_weight(cfg_weight),
    .cfg_is_bad(cfg_is_bad),
    .new_good_tokens(new_good_tokens),
    .new_bad_tokens(new_bad_tokens),
    .busy(busy)
`ifdef TTT_ROUTER_OVERFLOW_EN
    ,
    .overflow(overflow)
`endif
  );

  initial clock_fast = 1'b0;
  always #5 clock_fast = ~clock_fast;

  task automatic check(input string tag, input int observed, input int expected);
    vec_count++;
    if (observed !== expected) begin
      miscompares++;
      $display("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end else begin
      $display("ok   %s: %0d", tag, observed);
    end
  endtask

  task automatic step;
    @(posedge clock_fast);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic cfg(input int addr, input int w, input bit bad);
    cfg_write  = 1'b1;
    cfg_addr   = 2'(addr);
    cfg_weight = 4'(w);
    cfg_is_bad = bad;
    step();
    cfg_write  = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] starts, input logic [3:0] ends);
    src_token_start = starts;
    src_token_end   = ends;
    step();
    src_token_start = '0;
    src_token_end   = '0;
  endtask

  task automatic check_out(input string tag, input int good, input int bad);
    check({tag, ".good"}, int'(new_good_tokens), good);
    check({tag, ".bad"},  int'(new_bad_tokens),  bad);
  endtask

  initial begin
    reset = 1'b1;
    src_token_start = '0;
    src_token_end   = '0;
    cfg_write  = 1'b0;
    cfg_addr   = '0;
    cfg_weight = '0;
    cfg_is_bad = 1'b0;
    step();
    step();
    reset = 1'b0;
    check_out("reset", 0, 0);
    check("reset.busy", int'(busy), 0);
`ifdef TTT_ROUTER_OVERFLOW_EN
    check("reset.overflow", int'(overflow), 0);
`endif

    // Single good event, one-cycle output
    cfg(1, 3, 1'b0);
    cfg(2, -2, 1'b1);
    pulse(4'b0010, 4'b0000);
    check_out("t1.capture", 0, 0);
    check("t1.capture.busy", int'(busy), 1);
    step();
    check_out("t1.serve", 3, 0);
    check("t1.serve.busy", int'(busy), 0);
    step();
    check_out("t1.idle", 0, 0);

    // End on a bad-channel source: -(-2) = +2 on bad
    pulse(4'b0000, 4'b0100);
    step();
    check_out("bad.serve", 0, 2);
    step();
    check_out("bad.idle", 0, 0);

    // Four simultaneous starts, rr = 0
    do_reset();
    for (int i = 0; i < 4; i++) cfg(i, i + 1, 1'b0);
    pulse(4'b1111, 4'b0000);
    check("t2.capture.busy", int'(busy), 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check_out($sformatf("t2.out%0d", i), i + 1, 0);
      check($sformatf("t2.busy%0d", i), int'(busy), (i < 3) ? 1 : 0);
    end
    step();
    check_out("t2.idle", 0, 0);

    // Start and end together on source 0
    cfg(0, 5, 1'b0);
    pulse(4'b0001, 4'b0001);
    step();
    check_out("t3.start", 5, 0);
    step();
    check_out("t3.end", -5, 0);
    step();
    check_out("t3.idle", 0, 0);

    // Most-negative weight saturates on negation
    cfg(0, -8, 1'b0);
    pulse(4'b0001, 4'b0001);
    step();
    check_out("t4.start", -8, 0);
    step();
    check_out("t4.end", 7, 0);
    step();
    check_out("t4.idle", 0, 0);

    // Duplicate on source 3 is dropped; re-pulse of source 0 on its serving edge is kept
    do_reset();
    for (int i = 0; i < 4; i++) cfg(i, i + 1, 1'b0);
    pulse(4'b1111, 4'b0000);
    pulse(4'b1001, 4'b0000);
    check_out("t5.out0", 1, 0);
`ifdef TTT_ROUTER_OVERFLOW_EN
    check("t5.overflow", int'(overflow), 1);
`endif
    step();
    check_out("t5.out1", 2, 0);
    step();
    check_out("t5.out2", 3, 0);
    step();
    check_out("t5.out3", 4, 0);
    step();
    check_out("t5.out4", 1, 0);
    check("t5.busy", int'(busy), 0);
    step();
    check_out("t5.idle", 0, 0);

    // Reset with three events pending
    pulse(4'b0111, 4'b0000);
    check("t6.pending.busy", int'(busy), 1);
    do_reset();
    check_out("t6.reset", 0, 0);
    check("t6.reset.busy", int'(busy), 0);
`ifdef TTT_ROUTER_OVERFLOW_EN
    check("t6.reset.overflow", int'(overflow), 0);
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t6.after%0d.busy", i), int'(busy), 0);
      check_out($sformatf("t6.after%0d", i), 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
